// File: rtl/benes_stream_net.sv
// Pipelined, flow-controlled Benes permutation network with per-beat switch settings.
// Optional build macro BENES_BEAT_CNT_EN adds the O_BEAT_CNT output-handshake counter.
module benes_stream_net #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned PORT_NUM   = 32,
    parameter int unsigned TAG_WIDTH  = 8,
    localparam int unsigned SWITCH_NUM = PORT_NUM / 2,
    localparam int unsigned LAYER_NUM  = $clog2(PORT_NUM),
    localparam int unsigned STAGE_NUM  = 2 * LAYER_NUM - 1
) (
    input  logic                                     CLK,
    input  logic                                     RST_N,
    input  logic                                     I_VALID,
    output logic                                     I_READY,
    input  logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]     I_SWITCH_SET,
    input  logic [TAG_WIDTH-1:0]                     I_TAG,
    input  logic [0:PORT_NUM-1][DATA_WIDTH-1:0]      I_PORT,
    output logic                                     O_VALID,
    input  logic                                     O_READY,
    output logic [TAG_WIDTH-1:0]                     O_TAG,
`ifdef BENES_BEAT_CNT_EN
    output logic [31:0]                              O_BEAT_CNT,
`endif
    output logic [0:PORT_NUM-1][DATA_WIDTH-1:0]      O_PORT
);

    // Register k holds switch slices k..STAGE_NUM-1, packed back to back, slice k lowest.
    localparam int unsigned SW_IN_W  = STAGE_NUM * SWITCH_NUM;
    localparam int unsigned SW_TOT_W = SWITCH_NUM * STAGE_NUM * (STAGE_NUM + 1) / 2;

    function automatic int unsigned sw_off(input int unsigned k);
        return SWITCH_NUM * (k * STAGE_NUM - (k * (k - 1)) / 2);
    endfunction

    // Lane reached in stage s+1 by lane p leaving stage s.
    function automatic int unsigned wire_dst(input int unsigned s, input int unsigned p);
        int unsigned blk;
        int unsigned q;
        int unsigned base;
        if (s < LAYER_NUM - 1) begin
            blk  = PORT_NUM >> s;
            q    = p % blk;
            base = p - q;
            return (q % 2 == 0) ? base + q / 2 : base + blk / 2 + q / 2;
        end else begin
            blk  = PORT_NUM >> (2 * LAYER_NUM - 3 - s);
            q    = p % blk;
            base = p - q;
            return (q < blk / 2) ? base + 2 * q : base + 2 * (q - blk / 2) + 1;
        end
    endfunction

    // Index 0 is the input register; index s+1 holds the result of switch stage s.
    logic [STAGE_NUM:0]                                  vld_q, vld_d;
    logic [STAGE_NUM:0][TAG_WIDTH-1:0]                   tag_q, tag_d;
    logic [STAGE_NUM:0][0:PORT_NUM-1][DATA_WIDTH-1:0]    dat_q, dat_d;
    logic [SW_TOT_W-1:0]                                 sw_q, sw_d;

    logic [STAGE_NUM-1:0][0:PORT_NUM-1][DATA_WIDTH-1:0]  st_in;
    logic [STAGE_NUM-1:0][0:PORT_NUM-1][DATA_WIDTH-1:0]  st_out;
    logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]                sw_cur;
    logic [SW_IN_W-1:0]                                  sw_in;
    logic                                                adv;

    assign adv     = O_READY || !vld_q[STAGE_NUM];
    assign I_READY = adv;

    always_comb begin
        sw_in = '0;
        for (int unsigned s = 0; s < STAGE_NUM; s++) begin
            for (int unsigned j = 0; j < SWITCH_NUM; j++) begin
                sw_in[s * SWITCH_NUM + j] = I_SWITCH_SET[s][j];
            end
        end
    end

    always_comb begin
        sw_cur = '0;
        for (int unsigned k = 0; k < STAGE_NUM; k++) begin
            sw_cur[k] = sw_q[sw_off(k) +: SWITCH_NUM];
        end
    end

    // Inter-stage wiring followed by the 2x2 switches of each stage.
    always_comb begin
        st_in  = '0;
        st_out = '0;
        for (int unsigned s = 0; s < STAGE_NUM; s++) begin
            for (int unsigned p = 0; p < PORT_NUM; p++) begin
                if (s == 0) begin
                    st_in[s][p] = dat_q[s][p];
                end else begin
                    st_in[s][wire_dst(s - 1, p)] = dat_q[s][p];
                end
            end
            for (int unsigned j = 0; j < SWITCH_NUM; j++) begin
                if (sw_cur[s][j]) begin
                    st_out[s][2 * j]     = st_in[s][2 * j + 1];
                    st_out[s][2 * j + 1] = st_in[s][2 * j];
                end else begin
                    st_out[s][2 * j]     = st_in[s][2 * j];
                    st_out[s][2 * j + 1] = st_in[s][2 * j + 1];
                end
            end
        end
    end

    // Global advance: every register moves together or holds together.
    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        dat_d = dat_q;
        sw_d  = sw_q;
        if (adv) begin
            vld_d[0] = I_VALID;
            tag_d[0] = I_TAG;
            dat_d[0] = I_PORT;
            for (int unsigned s = 0; s < STAGE_NUM; s++) begin
                vld_d[s + 1] = vld_q[s];
                tag_d[s + 1] = tag_q[s];
                dat_d[s + 1] = st_out[s];
            end
            for (int unsigned k = 0; k < STAGE_NUM; k++) begin
                for (int unsigned i = 0; i < (STAGE_NUM - k) * SWITCH_NUM; i++) begin
                    if (k == 0) begin
                        sw_d[i] = sw_in[i];
                    end else begin
                        sw_d[sw_off(k) + i] = sw_q[sw_off(k - 1) + SWITCH_NUM + i];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_q <= '0;
            tag_q <= '0;
            dat_q <= '0;
            sw_q  <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
            dat_q <= dat_d;
            sw_q  <= sw_d;
        end
    end

    assign O_VALID = vld_q[STAGE_NUM];
    assign O_TAG   = tag_q[STAGE_NUM];
    assign O_PORT  = dat_q[STAGE_NUM];

`ifdef BENES_BEAT_CNT_EN
    // Output handshake counter, wraps naturally at 32 bits.
    logic [31:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (vld_q[STAGE_NUM] && O_READY) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign O_BEAT_CNT = beat_cnt_q;
`endif

endmodule

// File: tb/tb_benes_stream_net.sv
// Scoreboard bench for benes_stream_net (8 lanes x 16 bits, 4-bit tag).
// Expected beats come from a shuffle/unshuffle-by-bit-rotation model of the network.
`timescale 1ns/1ps
module tb_benes_stream_net;

    localparam int DW  = 16;
    localparam int PN  = 8;
    localparam int TW  = 4;
    localparam int LN  = 3;
    localparam int SN  = 2 * LN - 1;
    localparam int WN  = PN / 2;
    localparam int SWB = SN * WN;

    typedef logic [0:PN-1][DW-1:0] lanes_t;
    typedef logic [0:SN-1][0:WN-1] sw_t;
    typedef struct {
        logic [TW-1:0] tag;
        lanes_t        data;
    } beat_t;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          I_VALID;
    logic          I_READY;
    sw_t           I_SWITCH_SET;
    logic [TW-1:0] I_TAG;
    lanes_t        I_PORT;
    logic          O_VALID;
    logic          O_READY;
    logic [TW-1:0] O_TAG;
    lanes_t        O_PORT;
`ifdef BENES_BEAT_CNT_EN
    logic [31:0]   O_BEAT_CNT;
`endif

    benes_stream_net #(.DATA_WIDTH(DW), .PORT_NUM(PN), .TAG_WIDTH(TW)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .I_VALID      (I_VALID),
        .I_READY      (I_READY),
        .I_SWITCH_SET (I_SWITCH_SET),
        .I_TAG        (I_TAG),
        .I_PORT       (I_PORT),
        .O_VALID      (O_VALID),
        .O_READY      (O_READY),
        .O_TAG        (O_TAG),
`ifdef BENES_BEAT_CNT_EN
        .O_BEAT_CNT   (O_BEAT_CNT),
`endif
        .O_PORT       (O_PORT)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    beat_t       exp_q[$];
    logic [31:0] cnt_model = 32'd0;
    int          stall_cnt = 0;
    bit          rand_ready = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Unshuffle = rotate-right of the in-block index, shuffle = rotate-left.
    function automatic lanes_t model(input lanes_t din, input sw_t sw);
        lanes_t        cur;
        lanes_t        nxt;
        logic [DW-1:0] t;
        int            b, blk, q, base, d;
        cur = din;
        for (int s = 0; s < SN; s++) begin
            for (int j = 0; j < WN; j++) begin
                if (sw[s][j]) begin
                    t              = cur[2 * j];
                    cur[2 * j]     = cur[2 * j + 1];
                    cur[2 * j + 1] = t;
                end
            end
            if (s < SN - 1) begin
                b   = (s < LN - 1) ? LN - s : s - LN + 3;
                blk = 1 << b;
                nxt = cur;
                for (int p = 0; p < PN; p++) begin
                    base = p & ~(blk - 1);
                    q    = p & (blk - 1);
                    if (s < LN - 1) d = (q >> 1) | ((q & 1) << (b - 1));
                    else            d = ((q << 1) & (blk - 1)) | (q >> (b - 1));
                    nxt[base + d] = cur[p];
                end
                cur = nxt;
            end
        end
        return cur;
    endfunction

    function automatic lanes_t rnd_lanes();
        lanes_t r;
        for (int p = 0; p < PN; p++) r[p] = DW'($urandom);
        return r;
    endfunction

    // Monitor: pops the scoreboard on every output handshake and checks flow-control rules.
    logic          prev_stall = 1'b0;
    logic          prev_v;
    logic [TW-1:0] prev_t;
    lanes_t        prev_d;
    beat_t         e;

    always @(negedge CLK) begin
        if (!RST_N) begin
            chk("rst_o_valid", O_VALID, 1'b0);
            chk("rst_o_port", O_PORT, '0);
            chk("rst_o_tag", O_TAG, '0);
            chk("rst_i_ready", I_READY, 1'b1);
`ifdef BENES_BEAT_CNT_EN
            chk("rst_beat_cnt", O_BEAT_CNT, 32'd0);
`endif
            cnt_model  = 32'd0;
            prev_stall = 1'b0;
        end else begin
            chk("i_ready", I_READY, O_READY || !O_VALID);
            if (prev_stall) begin
                chk("stall_valid", O_VALID, prev_v);
                chk("stall_tag", O_TAG, prev_t);
                chk("stall_port", O_PORT, prev_d);
            end
`ifdef BENES_BEAT_CNT_EN
            chk("beat_cnt", O_BEAT_CNT, cnt_model);
`endif
            if (O_VALID && O_READY) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", O_VALID, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_tag", O_TAG, e.tag);
                    chk("out_port", O_PORT, e.data);
                end
                cnt_model = cnt_model + 32'd1;
            end
            prev_stall = O_VALID && !O_READY;
            prev_v     = O_VALID;
            prev_t     = O_TAG;
            prev_d     = O_PORT;
        end
    end

    task automatic set_ready();
        if (stall_cnt > 0) begin
            O_READY = 1'b0;
            stall_cnt--;
        end else begin
            O_READY = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            I_VALID = 1'b0;
            I_PORT  = rnd_lanes();
            @(posedge CLK);
            #1;
            set_ready();
        end
    endtask

    task automatic send(input logic [TW-1:0] tag, input lanes_t d, input sw_t sw, input lanes_t exp);
        beat_t b;
        I_VALID      = 1'b1;
        I_TAG        = tag;
        I_PORT       = d;
        I_SWITCH_SET = sw;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (I_READY) begin
                b.tag  = tag;
                b.data = exp;
                exp_q.push_back(b);
                @(posedge CLK);
                #1;
                I_VALID = 1'b0;
                set_ready();
                return;
            end
            @(posedge CLK);
            #1;
            set_ready();
        end
        chk("send_timeout", I_READY, 1'b1);
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        for (int i = 0; i < 100 && (exp_q.size() != 0 || O_VALID); i++) idle(1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    lanes_t id_l, x01, x67, d;
    sw_t    sw;
    int     n;

    initial begin
        RST_N        = 1'b0;
        I_VALID      = 1'b0;
        O_READY      = 1'b0;
        I_TAG        = '0;
        I_PORT       = '0;
        I_SWITCH_SET = '0;
        for (int p = 0; p < PN; p++) id_l[p] = DW'(p * 16);
        x01 = id_l; x01[0] = id_l[1]; x01[1] = id_l[0];
        x67 = id_l; x67[6] = id_l[7]; x67[7] = id_l[6];

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            I_VALID      = 1'b1;
            I_PORT       = rnd_lanes();
            I_TAG        = TW'($urandom);
            I_SWITCH_SET = SWB'($urandom);
            O_READY      = 1'($urandom_range(1));
        end
        @(posedge CLK);
        #1;
        RST_N   = 1'b1;
        I_VALID = 1'b0;
        O_READY = 1'b1;

        // Identity beat right after reset, with latency measurement.
        send(4'hA, id_l, '0, id_l);
        n = 0;
        do begin
            n++;
            @(negedge CLK);
        end while (!O_VALID && n < 20);
        chk("latency", 32'(n), 32'(SN + 1));
        @(posedge CLK);
        #1;
        drain();

        // Single crosses.
        sw = '0; sw[0][0] = 1'b1;
        send(4'h1, id_l, sw, x01);
        sw = '0; sw[4][3] = 1'b1;
        send(4'h2, id_l, sw, x67);
        drain();

        // Per-beat configuration, back to back.
        send(4'h3, id_l, '0, id_l);
        sw = '0; sw[0][0] = 1'b1;
        send(4'h4, id_l, sw, x01);
        send(4'h5, id_l, '0, id_l);
        drain();

        // Backpressure: ten tagged beats with a 3-cycle stall mid-stream.
        for (int t = 0; t < 10; t++) begin
            d  = rnd_lanes();
            sw = SWB'($urandom);
            send(TW'(t), d, sw, model(d, sw));
            if (t == 7) begin
                stall_cnt = 3;
                set_ready();
            end
        end
        drain();

        // Randomized streaming with random backpressure and bubbles.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) != 0) begin
                d  = rnd_lanes();
                sw = SWB'($urandom);
                send(TW'($urandom), d, sw, model(d, sw));
            end else begin
                idle(1);
            end
        end
        drain();

        // Reset with four beats in flight, oldest one on the output.
        for (int t = 0; t < 4; t++) send(TW'(t + 8), id_l, '0, id_l);
        idle(2);
        chk("pre_reset_valid", O_VALID, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_reset_valid", O_VALID, 1'b0);
        chk("async_reset_i_ready", I_READY, 1'b1);
        exp_q.delete();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        idle(12);
        drain();

`ifdef BENES_BEAT_CNT_EN
        // Counter wrap from near its limit.
        force dut.beat_cnt_q = 32'hFFFF_FFFE;
        cnt_model = 32'hFFFF_FFFE;
        @(posedge CLK);
        #1;
        release dut.beat_cnt_q;
        for (int t = 0; t < 3; t++) send(TW'(t), id_l, '0, id_l);
        drain();
        chk("beat_cnt_wrapped", O_BEAT_CNT, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
